// File: rtl/turn_controller.sv
// Turn sequencing for a user-vs-CPU game: arms the countdown, alternates turns, detects win/draw/timeout.
// Optional macro TURN_BCD_DISPLAY_EN adds a registered BCD view of timer_value.
module turn_controller #(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned MAX_TURNS = 42
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       move_valid,
  input  logic       user_win,
  input  logic       cpu_done,
  input  logic       cpu_win,
  input  logic [5:0] timer_value,
  input  logic       time_out,
  output logic       user_turn,
  output logic       timer_reset,
  output logic       tick_1s,
  output logic       cpu_go,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [7:0] turn_count,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [7:0] TURN_MAX = 8'(MAX_TURNS);

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_USER = 2'b01;
  localparam logic [1:0] WIN_CPU  = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [2:0] {IDLE, ARM, USER, CPU, OVER} state_t;

  state_t        state, next_state;
  logic [PW-1:0] prescaler;
  logic [7:0]    count_inc;
  logic [1:0]    winner_d;
  logic [7:0]    count_d;
  logic          user_turn_d, timer_reset_d, tick_d, cpu_go_d, game_over_d;

  // Saturating increment so the count can never wrap past MAX_TURNS
  assign count_inc = (turn_count >= TURN_MAX) ? TURN_MAX : turn_count + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    winner_d   = winner;
    count_d    = turn_count;
    case (state)
      IDLE, OVER: begin
        if (start) begin
          next_state = ARM;
          winner_d   = WIN_NONE;
          count_d    = 8'd0;
        end
      end
      ARM: next_state = USER;
      USER: begin
        // A committed move takes priority over a coincident timeout
        if (move_valid) begin
          count_d = count_inc;
          if (user_win) begin
            next_state = OVER;
            winner_d   = WIN_USER;
          end else if (count_inc == TURN_MAX) begin
            next_state = OVER;
            winner_d   = WIN_DRAW;
          end else begin
            next_state = CPU;
          end
        end else if (time_out) begin
          next_state = OVER;
          winner_d   = WIN_CPU;
        end
      end
      CPU: begin
        if (cpu_done) begin
          count_d = count_inc;
          if (cpu_win) begin
            next_state = OVER;
            winner_d   = WIN_CPU;
          end else if (count_inc == TURN_MAX) begin
            next_state = OVER;
            winner_d   = WIN_DRAW;
          end else begin
            next_state = ARM;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state so the registered copies line up with state
  always_comb begin
    user_turn_d   = 1'b0;
    timer_reset_d = 1'b1;
    tick_d        = 1'b0;
    cpu_go_d      = 1'b0;
    game_over_d   = 1'b0;
    case (next_state)
      USER: begin
        user_turn_d   = 1'b1;
        timer_reset_d = 1'b0;
        tick_d        = (state == USER) && (prescaler == PRE_LAST);
      end
      CPU:     cpu_go_d    = (state != CPU);
      OVER:    game_over_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler   <= '0;
      user_turn   <= 1'b0;
      timer_reset <= 1'b1;
      tick_1s     <= 1'b0;
      cpu_go      <= 1'b0;
      game_over   <= 1'b0;
      winner      <= WIN_NONE;
      turn_count  <= 8'd0;
    end else begin
      if (state == USER) prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + PW'(1);
      else               prescaler <= '0;
      user_turn   <= user_turn_d;
      timer_reset <= timer_reset_d;
      tick_1s     <= tick_d;
      cpu_go      <= cpu_go_d;
      game_over   <= game_over_d;
      winner      <= winner_d;
      turn_count  <= count_d;
    end
  end

`ifdef TURN_BCD_DISPLAY_EN
  logic [5:0] secs;

  // Timer readings above 60 are shown as 60
  assign secs = (timer_value > 6'd60) ? 6'd60 : timer_value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_tens <= 4'd0;
      bcd_ones <= 4'd0;
    end else begin
      bcd_tens <= 4'(secs / 6'd10);
      bcd_ones <= 4'(secs % 6'd10);
    end
  end
`else
  logic unused_timer_value;

  assign unused_timer_value = ^timer_value;
  assign bcd_tens = 4'd0;
  assign bcd_ones = 4'd0;
`endif

endmodule

// File: tb/tb_turn_controller.sv
// Self-checking bench for turn_controller: vector table through a scoreboard queue plus timeout/reset sequences.
module tb_turn_controller;

  localparam int unsigned CLK_HZ    = 10;
  localparam int unsigned MAX_TURNS = 4;

  logic       clk, reset, start, move_valid, user_win, cpu_done, cpu_win, time_out;
  logic [5:0] timer_value;
  logic       user_turn, timer_reset, tick_1s, cpu_go, game_over;
  logic [1:0] winner;
  logic [7:0] turn_count;
  logic [3:0] bcd_tens, bcd_ones;

  int n_cmp = 0;
  int n_bad = 0;

  turn_controller #(.CLK_HZ(CLK_HZ), .MAX_TURNS(MAX_TURNS)) dut (
    .clk(clk), .reset(reset), .start(start), .move_valid(move_valid),
    .user_win(user_win), .cpu_done(cpu_done), .cpu_win(cpu_win),
    .timer_value(timer_value), .time_out(time_out),
    .user_turn(user_turn), .timer_reset(timer_reset), .tick_1s(tick_1s),
    .cpu_go(cpu_go), .game_over(game_over), .winner(winner),
    .turn_count(turn_count), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st, mv, uw, cd, cw, to;
    logic [5:0] tv;
    logic       ut, tr, cg, go;
    logic [1:0] win;
    logic [7:0] tc;
    logic [3:0] bt, bo;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic st, mv, uw, cd, cw, to, input logic [5:0] tv,
                              input logic ut, tr, cg, go, input logic [1:0] win,
                              input logic [7:0] tc, input logic [3:0] bt, bo);
    vec_t v;
    v.st = st; v.mv = mv; v.uw = uw; v.cd = cd; v.cw = cw; v.to = to; v.tv = tv;
    v.ut = ut; v.tr = tr; v.cg = cg; v.go = go; v.win = win; v.tc = tc;
    v.bt = bt; v.bo = bo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic st, mv, uw, cd, cw, to);
    @(negedge clk);
    start = st; move_valid = mv; user_win = uw; cpu_done = cd; cpu_win = cw; time_out = to;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t e;
    int   last_tick, n_ticks, first_tick;

    reset = 1'b1; start = 1'b0; move_valid = 1'b0; user_win = 1'b0;
    cpu_done = 1'b0; cpu_win = 1'b0; time_out = 1'b0; timer_value = 6'd0;
    #2;
    chk("rst_user_turn", user_turn, 0);
    chk("rst_timer_reset", timer_reset, 1);
    chk("rst_tick", tick_1s, 0);
    chk("rst_cpu_go", cpu_go, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_winner", winner, 0);
    chk("rst_turn_count", turn_count, 0);
    chk("rst_bcd", {bcd_tens, bcd_ones}, 0);
    @(negedge clk);
    reset = 1'b0;

    //            st mv uw cd cw to tv    ut tr cg go win tc  bt bo
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 47,  0, 1, 0, 0, 0, 0,  4, 7));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 63,  0, 1, 0, 0, 0, 0,  6, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 60,  0, 1, 0, 0, 0, 0,  6, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 59,  1, 0, 0, 0, 0, 0,  5, 9));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 9,   0, 1, 1, 0, 0, 1,  0, 9));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10,  0, 1, 0, 0, 0, 1,  1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 33,  0, 1, 0, 0, 0, 1,  3, 3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 20,  0, 1, 0, 0, 0, 2,  2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 2,  0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 47,  0, 1, 1, 0, 0, 3,  4, 7));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 62,  0, 1, 0, 1, 3, 4,  6, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 5,   0, 1, 0, 1, 3, 4,  0, 5));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0,   0, 1, 0, 1, 1, 1,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,   0, 1, 0, 1, 2, 0,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1,  0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0,   0, 1, 0, 1, 2, 2,  0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start = vecs[i].st; move_valid = vecs[i].mv; user_win = vecs[i].uw;
      cpu_done = vecs[i].cd; cpu_win = vecs[i].cw; time_out = vecs[i].to;
      timer_value = vecs[i].tv;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk($sformatf("v%0d_queue", i), 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("v%0d_user_turn", i), user_turn, e.ut);
        chk($sformatf("v%0d_timer_reset", i), timer_reset, e.tr);
        chk($sformatf("v%0d_tick", i), tick_1s, 0);
        chk($sformatf("v%0d_cpu_go", i), cpu_go, e.cg);
        chk($sformatf("v%0d_game_over", i), game_over, e.go);
        chk($sformatf("v%0d_winner", i), winner, e.win);
        chk($sformatf("v%0d_turn_count", i), turn_count, e.tc);
`ifdef TURN_BCD_DISPLAY_EN
        chk($sformatf("v%0d_bcd_tens", i), bcd_tens, e.bt);
        chk($sformatf("v%0d_bcd_ones", i), bcd_ones, e.bo);
`else
        chk($sformatf("v%0d_bcd_tens", i), bcd_tens, 0);
        chk($sformatf("v%0d_bcd_ones", i), bcd_ones, 0);
`endif
      end
    end

    // Timeout game: ticks every CLK_HZ cycles in USER, then the CPU wins on time_out
    cyc(1, 0, 0, 0, 0, 0);
    chk("to_arm_timer_reset", timer_reset, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("to_user_turn", user_turn, 1);
    last_tick = 0; n_ticks = 0; first_tick = 0;
    for (int n = 1; n <= 600; n++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (tick_1s === 1'b1) begin
        if (n_ticks == 0) first_tick = n;
        else chk($sformatf("tick_interval_%0d", n), n - last_tick, CLK_HZ);
        last_tick = n;
        n_ticks++;
      end
    end
    chk("tick_first", first_tick, CLK_HZ);
    chk("tick_count", n_ticks, 600 / CLK_HZ);
    cyc(0, 0, 0, 0, 0, 1);
    chk("to_game_over", game_over, 1);
    chk("to_winner", winner, 2);
    chk("to_user_turn_off", user_turn, 0);
    chk("to_tick_off", tick_1s, 0);

    // Mid-game asynchronous reset
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("mr_cpu_go", cpu_go, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("mr_arm_timer_reset", timer_reset, 1);
    chk("mr_arm_user_turn", user_turn, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("mr_user_turn", user_turn, 1);
    chk("mr_turn_count", turn_count, 2);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("ar_user_turn", user_turn, 0);
    chk("ar_timer_reset", timer_reset, 1);
    chk("ar_turn_count", turn_count, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 1, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("ar_idle_user_turn", user_turn, 0);
    chk("ar_idle_timer_reset", timer_reset, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("ar_restart_user_turn", user_turn, 1);
    chk("ar_restart_count", turn_count, 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("ar_user_win", winner, 1);
    chk("ar_user_win_count", turn_count, 1);
    chk("ar_user_win_over", game_over, 1);
    cyc(0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
